// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch state encoding, the PC alignment mask and default widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [1:0] ALIGN_MASK  = 2'b11;
    localparam int         DEF_ADDR_W  = 32;
    localparam int         DEF_DATA_W  = 32;
    localparam int         DEF_TIMEOUT = 16;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating count of consecutive un-acked memory request cycles.
// o_hit flags the increment that reaches TIMEOUT, and stays high while saturated and still incrementing.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_hit
);

    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = i_inc && !i_clear && (r_count >= LIMIT_M1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: samples the PC, reads instruction memory over req/ack and hands the word downstream.
// pc_en pulses only on downstream acceptance so the PC advances on consumption.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_fetch_err;
    logic              r_misal_hold;

    logic w_in_req;
    logic w_tmo_clear;
    logic w_tmo_inc;
    logic w_tmo_hit;
    logic w_misaligned;

    // Timeout window restarts whenever a request phase (REQ or DROP) is entered.
    assign w_in_req     = (r_state == ST_REQ) || (r_state == ST_DROP);
    assign w_tmo_inc    = w_in_req && !mem_ack;
    assign w_tmo_clear  = !w_in_req || ((r_state == ST_REQ) && flush && !mem_ack);
    assign w_misaligned = (pc[1:0] & ALIGN_MASK) != 2'b00;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_tmo_clear),
        .i_inc   (w_tmo_inc),
        .o_hit   (w_tmo_hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_misal_hold  <= 1'b0;
        end else begin
            if (w_tmo_hit) begin
                r_fetch_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // A misaligned PC parks the unit until a redirect supplies a new one.
                    if (flush) begin
                        r_misal_hold <= 1'b0;
                    end else if (r_misal_hold) begin
                        r_state <= ST_IDLE;
                    end else if (w_misaligned) begin
                        r_fetch_err  <= 1'b1;
                        r_misal_hold <= 1'b1;
                    end else begin
                        r_mem_addr <= pc;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!flush) begin
                            r_instr       <= mem_rdata;
                            r_instr_pc    <= r_mem_addr;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (flush) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (flush || instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_en       = r_instr_valid && instr_ready && !flush;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations checked with immediate assertions.
// The bench models program_counter by adding 4 to pc on each edge where pc_en was high.
module tb_fetch_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int total = 0;
    int bad = 0;
    int pcEnCount = 0;

    fetch_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample pc_en before the edge, advance the modelled PC after it, return at the next negedge.
    task automatic applyStimulus();
        logic adv;
        #1;
        adv = pc_en;
        @(posedge clk);
        #1;
        if (adv) begin
            pc = pc + 32'd4;
            pcEnCount++;
        end
        @(negedge clk);
    endtask

    initial begin
        rstn        = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_valid", 64'(instr_valid), 64'd0);
        checkOutput("rst_err", 64'(fetch_err), 64'd0);
        checkOutput("rst_pc_en", 64'(pc_en), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_instr", 64'(instr), 64'd0);
        rstn = 1'b1;

        // Basic fetch at pc=0 with a one-cycle memory.
        applyStimulus();
        checkOutput("t1_mem_req", 64'(mem_req), 64'd1);
        checkOutput("t1_mem_addr", 64'(mem_addr), 64'h0);
        checkOutput("t1_valid_early", 64'(instr_valid), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h20080005;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t1_req_drop", 64'(mem_req), 64'd0);
        checkOutput("t1_valid", 64'(instr_valid), 64'd1);
        checkOutput("t1_instr", 64'(instr), 64'h20080005);
        checkOutput("t1_instr_pc", 64'(instr_pc), 64'h0);
        checkOutput("t1_pc_en", 64'(pc_en), 64'd1);
        applyStimulus();
        checkOutput("t1_valid_done", 64'(instr_valid), 64'd0);
        checkOutput("t1_pc_en_count", 64'(pcEnCount), 64'd1);
        applyStimulus();
        checkOutput("t1_next_req", 64'(mem_req), 64'd1);
        checkOutput("t1_next_addr", 64'(mem_addr), 64'h4);

        // Backpressure on the word fetched from 0x4.
        instr_ready = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = 32'h8C090010;
        applyStimulus();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", 64'(instr_valid), 64'd1);
            checkOutput("t2_hold_instr", 64'(instr), 64'h8C090010);
            checkOutput("t2_hold_pc", 64'(instr_pc), 64'h4);
            checkOutput("t2_hold_pc_en", 64'(pc_en), 64'd0);
            checkOutput("t2_hold_req", 64'(mem_req), 64'd0);
            applyStimulus();
        end
        instr_ready = 1'b1;
        #1;
        checkOutput("t2_pc_en", 64'(pc_en), 64'd1);
        applyStimulus();
        checkOutput("t2_valid_done", 64'(instr_valid), 64'd0);
        checkOutput("t2_pc_en_count", 64'(pcEnCount), 64'd2);

        // Flush while the request to 0x8 is outstanding; the late word must be dropped.
        applyStimulus();
        checkOutput("t3_req", 64'(mem_req), 64'd1);
        checkOutput("t3_addr", 64'(mem_addr), 64'h8);
        flush = 1'b1;
        pc    = 32'h40;
        applyStimulus();
        flush = 1'b0;
        checkOutput("t3_drop_req0", 64'(mem_req), 64'd1);
        applyStimulus();
        checkOutput("t3_drop_req1", 64'(mem_req), 64'd1);
        applyStimulus();
        checkOutput("t3_drop_req2", 64'(mem_req), 64'd1);
        checkOutput("t3_drop_addr", 64'(mem_addr), 64'h8);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t3_req_released", 64'(mem_req), 64'd0);
        checkOutput("t3_no_valid", 64'(instr_valid), 64'd0);
        checkOutput("t3_instr_kept", 64'(instr), 64'h8C090010);
        applyStimulus();
        checkOutput("t3_new_req", 64'(mem_req), 64'd1);
        checkOutput("t3_new_addr", 64'(mem_addr), 64'h40);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3C011001;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t3_instr", 64'(instr), 64'h3C011001);
        checkOutput("t3_instr_pc", 64'(instr_pc), 64'h40);
        applyStimulus();
        checkOutput("t3_pc_en_count", 64'(pcEnCount), 64'd3);

        // Misaligned PC raises fetch_err and blocks requests until a redirect.
        pc = 32'h6;
        applyStimulus();
        checkOutput("t4_err", 64'(fetch_err), 64'd1);
        checkOutput("t4_no_req0", 64'(mem_req), 64'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("t4_no_req1", 64'(mem_req), 64'd0);
        flush = 1'b1;
        pc    = 32'h8;
        applyStimulus();
        flush = 1'b0;
        checkOutput("t4_flush_no_req", 64'(mem_req), 64'd0);
        applyStimulus();
        checkOutput("t4_req", 64'(mem_req), 64'd1);
        checkOutput("t4_addr", 64'(mem_addr), 64'h8);
        checkOutput("t4_err_sticky", 64'(fetch_err), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h01095020;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t4_instr", 64'(instr), 64'h01095020);
        checkOutput("t4_instr_pc", 64'(instr_pc), 64'h8);
        applyStimulus();
        checkOutput("t4_pc_en_count", 64'(pcEnCount), 64'd4);

        // Asynchronous reset in the middle of the request to 0xC.
        applyStimulus();
        checkOutput("t6_req_before", 64'(mem_req), 64'd1);
        checkOutput("t6_addr_before", 64'(mem_addr), 64'hC);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t6_async_req", 64'(mem_req), 64'd0);
        checkOutput("t6_async_addr", 64'(mem_addr), 64'd0);
        checkOutput("t6_async_err", 64'(fetch_err), 64'd0);
        checkOutput("t6_async_instr", 64'(instr), 64'd0);
        checkOutput("t6_async_instr_pc", 64'(instr_pc), 64'd0);
        checkOutput("t6_async_valid", 64'(instr_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rstn      = 1'b1;
        pc        = 32'h100;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t6_restart_req", 64'(mem_req), 64'd1);
        checkOutput("t6_restart_addr", 64'(mem_addr), 64'h100);
        checkOutput("t6_stray_valid", 64'(instr_valid), 64'd0);

        // Memory silent: fetch_err after 16 un-acked REQ cycles, request persists.
        for (int i = 0; i < 15; i++) begin
            applyStimulus();
        end
        checkOutput("t5_err_before", 64'(fetch_err), 64'd0);
        checkOutput("t5_req_before", 64'(mem_req), 64'd1);
        applyStimulus();
        checkOutput("t5_err", 64'(fetch_err), 64'd1);
        checkOutput("t5_req", 64'(mem_req), 64'd1);
        applyStimulus();
        applyStimulus();
        checkOutput("t5_req_late", 64'(mem_req), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAC0A0004;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("t5_valid", 64'(instr_valid), 64'd1);
        checkOutput("t5_instr", 64'(instr), 64'hAC0A0004);
        checkOutput("t5_instr_pc", 64'(instr_pc), 64'h100);
        checkOutput("t5_err_sticky", 64'(fetch_err), 64'd1);
        applyStimulus();
        checkOutput("t5_valid_done", 64'(instr_valid), 64'd0);
        checkOutput("t5_pc_en_count", 64'(pcEnCount), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
